spi_cmd_master: RTL and testbench

Single-clock SPI command initiator that drives the 11-bit MOSI frame format used by our SPI RAM wrapper and captures 8-bit read data returned on MISO. It sits between a parallel command/response interface (CPU or test sequencer side) and the wrapper's SS_n/MOSI/MISO pins. It also tracks the read-address/read-data pairing the RAM wrapper requires.

---
 rtl/spi_cmd_master.sv | 185 ++++++++++++++++++
 tb/tb_spi_cmd_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI command initiator for the SPI RAM wrapper: serialises 11-bit command frames
// on MOSI and captures the 8-bit read byte returned on MISO during RD_DATA frames.
module spi_cmd_master #(
    parameter int FRAME_LEN = 23,
    parameter int RD_START  = 15,
    parameter int GAP_LEN   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_type,
    input  logic [7:0] i_cmd_data,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_err,
    output logic       o_busy,
    output logic       o_ss_n,
    output logic       o_mosi,
    input  logic       i_miso
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_CYC = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] HDR_END  = CW'(11);
    localparam logic [CW-1:0] RD_FIRST = CW'(RD_START);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_START + 7);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

    localparam logic [1:0] T_WR_ADDR = 2'd0;
    localparam logic [1:0] T_WR_DATA = 2'd1;
    localparam logic [1:0] T_RD_ADDR = 2'd2;
    localparam logic [1:0] T_RD_DATA = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_WAIT  = 3'd2,
        S_RECV  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    function automatic logic [2:0] frame_hdr(input logic [1:0] cmd_type);
        case (cmd_type)
            T_WR_ADDR: frame_hdr = 3'b000;
            T_WR_DATA: frame_hdr = 3'b001;
            T_RD_ADDR: frame_hdr = 3'b110;
            default:   frame_hdr = 3'b111;
        endcase
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cyc_nxt;
    logic [10:0]     r_shift;
    logic [10:0]     w_shift_nxt;
    logic [7:0]      r_rx;
    logic [7:0]      w_rx_nxt;
    logic [1:0]      r_type;
    logic            w_accept;
    logic            w_frame_end;
    logic            r_ss_n;
    logic            r_busy;
    logic            r_ready;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic            r_rsp_err;
    logic            r_rd_pending;

    // Next-state, frame-cycle counter and serial datapath decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cyc_nxt   = r_cnt + CW'(1);
        w_shift_nxt = r_shift;
        w_rx_nxt    = r_rx;
        w_accept    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {frame_hdr(i_cmd_type), i_cmd_data};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT, S_WAIT, S_RECV: begin
                w_shift_nxt = {r_shift[9:0], 1'b0};
                w_cnt_nxt   = w_cyc_nxt;
                if (r_state == S_RECV) begin
                    w_rx_nxt = {r_rx[6:0], i_miso};
                end else begin
                    w_rx_nxt = r_rx;
                end
                // The state names the phase of the cycle about to start.
                if (r_cnt == LAST_CYC) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end else if (w_cyc_nxt < HDR_END) begin
                    w_state_nxt = S_SHIFT;
                end else if ((w_cyc_nxt >= RD_FIRST) && (w_cyc_nxt <= RD_LAST)) begin
                    w_state_nxt = S_RECV;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cyc_nxt;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Frame sequencing state, serial registers and pin-facing status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_rx    <= '0;
            r_type  <= T_WR_ADDR;
            r_ss_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_rx    <= w_rx_nxt;
            if (w_accept) begin
                r_type <= i_cmd_type;
            end
            r_ss_n  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Read response generation and RD_ADDR/RD_DATA pairing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_rsp_err    <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            r_rsp_valid <= w_frame_end && (r_type == T_RD_DATA);
            if (w_frame_end) begin
                case (r_type)
                    T_RD_ADDR: r_rd_pending <= 1'b1;
                    T_RD_DATA: begin
                        r_rsp_data   <= w_rx_nxt;
                        r_rsp_err    <= ~r_rd_pending;
                        r_rd_pending <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_ss_n      = r_ss_n;
    assign o_mosi      = r_shift[10];
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: a SPI RAM wrapper model decodes MOSI
// frames and answers reads on MISO; expected frames/responses are queued at issue.
module tb_spi_cmd_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       ss_n;
    logic       mosi;
    logic       miso;

    spi_cmd_master dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_type  (cmd_type),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy),
        .o_ss_n      (ss_n),
        .o_mosi      (mosi),
        .i_miso      (miso)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [10:0] exp_frame_q[$];
    logic [8:0]  exp_rsp_q[$];

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  d;
        logic [10:0] frame;
        logic        has_rsp;
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Wrapper model and frame/response monitor, sampled on the falling edge.
    int          lowcnt = 0;
    logic [10:0] mon_bits = 11'd0;
    logic        prev_ss = 1'b1;
    logic        rd_active = 1'b0;
    logic        mem_ready = 1'b0;
    logic        abort_ok = 1'b0;
    logic [7:0]  waddr = 8'h00;
    logic [7:0]  raddr = 8'h00;
    logic [7:0]  mem [256];
    logic [10:0] ef;
    logic [8:0]  er;

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hC3;
            mem_ready = 1'b1;
        end
        miso = 1'b0;
        if (ss_n === 1'b0) begin
            if (prev_ss !== 1'b0) begin
                lowcnt   = 0;
                mon_bits = 11'd0;
            end
            if (lowcnt < 11) mon_bits = {mon_bits[9:0], mosi};
            if (lowcnt == 10) begin
                if (exp_frame_q.size() == 0) begin
                    n_total++;
                    $display("FAIL frame_unexpected: got frame %03h, expected none", mon_bits);
                end else begin
                    ef = exp_frame_q.pop_front();
                    check("frame_bits", {21'd0, mon_bits}, {21'd0, ef});
                end
                check("busy_in_frame", {31'd0, busy}, 32'd1);
                check("ready_in_frame", {31'd0, cmd_ready}, 32'd0);
                case (mon_bits[10:8])
                    3'b000: waddr = mon_bits[7:0];
                    3'b001: mem[waddr] = mon_bits[7:0];
                    3'b110: raddr = mon_bits[7:0];
                    3'b111: rd_active = 1'b1;
                    default: begin
                    end
                endcase
            end
            if (rd_active && lowcnt >= 15 && lowcnt <= 22) begin
                er[7:0] = mem[raddr];
                miso = er[22 - lowcnt];
            end
            lowcnt++;
        end else if (ss_n === 1'b1 && prev_ss === 1'b0) begin
            if (!abort_ok) check("ss_low_len", lowcnt, 32'd23);
            rd_active = 1'b0;
        end
        if (rsp_valid === 1'b1) begin
            check("rsp_first_gap_cycle", {30'd0, prev_ss, ss_n}, 32'd1);
            if (exp_rsp_q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got rsp_valid data %02h err %b, expected no response", rsp_data, rsp_err);
            end else begin
                er = exp_rsp_q.pop_front();
                check("rsp_data", {24'd0, rsp_data}, {24'd0, er[7:0]});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, er[8]});
            end
        end
        prev_ss = ss_n;
    end

    task automatic issue(input logic [1:0] t, input logic [7:0] d, input logic [10:0] frame,
                         input logic has_rsp, input logic [7:0] rdata, input logic err);
        int n;
        exp_frame_q.push_back(frame);
        if (has_rsp) exp_rsp_q.push_back({err, rdata});
        @(negedge clk);
        cmd_type  = t;
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL issue_timeout: cmd_ready %b, expected 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL idle_timeout: cmd_ready %b, expected 1", cmd_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[12];
    vec_t bt[4];
    int   acc[4];

    initial begin
        vecs[0]  = '{2'd0, 8'h3C, 11'h03C, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{2'd0, 8'h10, 11'h010, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{2'd1, 8'hA5, 11'h1A5, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{2'd2, 8'h10, 11'h610, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{2'd3, 8'h00, 11'h700, 1'b1, 8'hA5, 1'b0};
        vecs[5]  = '{2'd0, 8'h20, 11'h020, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{2'd1, 8'h5A, 11'h15A, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{2'd2, 8'h20, 11'h620, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{2'd2, 8'h20, 11'h620, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{2'd3, 8'hFF, 11'h7FF, 1'b1, 8'h5A, 1'b0};
        vecs[10] = '{2'd1, 8'h81, 11'h181, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{2'd3, 8'h3C, 11'h73C, 1'b1, 8'h81, 1'b1};
        bt[0]    = '{2'd0, 8'h30, 11'h030, 1'b0, 8'h00, 1'b0};
        bt[1]    = '{2'd1, 8'h77, 11'h177, 1'b0, 8'h00, 1'b0};
        bt[2]    = '{2'd2, 8'h30, 11'h630, 1'b0, 8'h00, 1'b0};
        bt[3]    = '{2'd3, 8'h00, 11'h700, 1'b1, 8'h77, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ss_n", {31'd0, ss_n}, 32'd1);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

        // Reset and cmd_valid on the same edge: reset wins.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = 2'd1; cmd_data = 8'hEE;
        @(posedge clk);
        #1;
        check("rst_vs_valid_ss_n", {31'd0, ss_n}, 32'd1);
        check("rst_vs_valid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;

        // RD_DATA with no preceding RD_ADDR: wrapper read address 0 holds 8'hC3.
        issue(2'd3, 8'h00, 11'h700, 1'b1, 8'hC3, 1'b1);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].t, vecs[i].d, vecs[i].frame, vecs[i].has_rsp, vecs[i].rdata, vecs[i].err);
            wait_idle();
        end

        // Back-to-back commands with cmd_valid held high.
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            cmd_type = bt[k].t;
            cmd_data = bt[k].d;
            exp_frame_q.push_back(bt[k].frame);
            if (bt[k].has_rsp) exp_rsp_q.push_back({bt[k].err, bt[k].rdata});
            n = 0;
            while (cmd_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                n_total++;
                $display("FAIL b2b_timeout: cmd_ready %b, expected 1", cmd_ready);
            end
            @(posedge clk);
            #1;
            acc[k] = cyc;
            if (k > 0) check("accept_spacing", acc[k] - acc[k-1], 32'd25);
        end
        cmd_valid = 1'b0;
        wait_idle();

        // Reset during frame cycle 17 of an RD_DATA that had a pending RD_ADDR.
        issue(2'd2, 8'h30, 11'h630, 1'b0, 8'h00, 1'b0);
        wait_idle();
        issue(2'd3, 8'h00, 11'h700, 1'b0, 8'h00, 1'b0);
        abort_ok = 1'b1;
        repeat (17) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ss_n", {31'd0, ss_n}, 32'd1);
        check("abort_mosi", {31'd0, mosi}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        abort_ok = 1'b0;
        issue(2'd3, 8'h00, 11'h700, 1'b1, 8'h77, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("frames_left", exp_frame_q.size(), 32'd0);
        check("rsps_left", exp_rsp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
